mpu_ip_control: RTL and testbench

//  Instruction pointer and sequencing stage directly downstream of the MPU execution stage.
//  - Consumes execution outputs each cycle: ip_incr/ip_load/ip_data, user_irq, hm_start.
//  - Owns the IP register that addresses program memory.
//  - Produces a retire strobe (commit) that gates register-file writes.
//  - Stalls on host-memory loads and on user interrupts; halts with a fault code on illegal sequencing.

---
 rtl/mpu_ip_control.sv | 133 +++++++++++++
 tb/tb_mpu_ip_control.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mpu_ip_control.sv
// mpu_ip_control: instruction pointer / sequencing stage after the MPU execution stage
// Inputs : sys_clk, sys_rst_n (async, active low), en, ip_incr, ip_load, ip_data,
//          user_irq, hm_start, hm_ack, irq_clear
// Outputs: ip, exec_en, commit (gates register-file writes), hm_req, irq, fault, fault_code
module mpu_ip_control #(
  parameter int CODE_BYTES = 4096,
  parameter int HM_TIMEOUT = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [15:0] ip_incr,
  input  logic        ip_load,
  input  logic [15:0] ip_data,
  input  logic        user_irq,
  input  logic        hm_start,
  input  logic        hm_ack,
  input  logic        irq_clear,
  output logic [15:0] ip,
  output logic        exec_en,
  output logic        commit,
  output logic        hm_req,
  output logic        irq,
  output logic        fault,
  output logic [1:0]  fault_code
);
  localparam int CW = $clog2(HM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RUN, HM_WAIT, IRQ_WAIT, HALT} state_t;
  state_t state_q, state_d;
  logic [15:0] ip_q, ip_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hm_req_q, hm_req_d, irq_q, irq_d, fault_q, fault_d;
  logic [1:0] code_q, code_d;
  logic [15:0] seq_ip, nip;
  logic nip_oob, seq_oob;
  // seq_ip is the fall-through address; interrupts and host-load completions never redirect
  assign seq_ip  = ip_q + ip_incr;
  assign nip     = ip_load ? ip_data : seq_ip;
  assign nip_oob = 32'(nip) >= CODE_BYTES;
  assign seq_oob = 32'(seq_ip) >= CODE_BYTES;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      ip_q     <= '0;
      cnt_q    <= '0;
      hm_req_q <= 1'b0;
      irq_q    <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      cnt_q    <= cnt_d;
      hm_req_q <= hm_req_d;
      irq_q    <= irq_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    cnt_d    = cnt_q;
    hm_req_d = 1'b0;
    irq_d    = irq_q;
    fault_d  = fault_q;
    code_d   = code_q;
    // fault/fault_code survive en low so the CPU can read them; cleared on IDLE->RUN
    if (!en) begin
      state_d = IDLE;
      ip_d    = '0;
      irq_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          fault_d = 1'b0;
          code_d  = 2'd0;
        end
        RUN: begin
          if (ip_incr == '0) begin
            state_d = HALT;
            fault_d = 1'b1;
            code_d  = 2'd3;
          end else if (hm_start) begin
            state_d  = HM_WAIT;
            hm_req_d = 1'b1;
            cnt_d    = '0;
          end else if (nip_oob) begin
            state_d = HALT;
            fault_d = 1'b1;
            code_d  = 2'd1;
          end else if (user_irq) begin
            state_d = IRQ_WAIT;
            ip_d    = seq_ip;
            irq_d   = 1'b1;
          end else begin
            ip_d = nip;
          end
        end
        HM_WAIT: begin
          // an ack on the timeout cycle wins over the timeout
          if (hm_ack) begin
            state_d = seq_oob ? HALT : RUN;
            ip_d    = seq_oob ? ip_q : seq_ip;
            fault_d = seq_oob;
            code_d  = seq_oob ? 2'd1 : code_q;
          end else if (cnt_q == CW'(HM_TIMEOUT)) begin
            state_d = HALT;
            fault_d = 1'b1;
            code_d  = 2'd2;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        IRQ_WAIT: begin
          state_d = irq_clear ? RUN : IRQ_WAIT;
          irq_d   = ~irq_clear;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    ip         = ip_q;
    exec_en    = state_q == RUN;
    commit     = (exec_en & ~hm_start) | ((state_q == HM_WAIT) & hm_ack);
    hm_req     = hm_req_q;
    irq        = irq_q;
    fault      = fault_q;
    fault_code = code_q;
  end
endmodule

// File: tb/tb_mpu_ip_control.sv
// tb_mpu_ip_control: directed scoreboard bench for mpu_ip_control
module tb_mpu_ip_control;
  localparam int S_IP = 0, S_EX = 1, S_CM = 2, S_HR = 3, S_IRQ = 4, S_F = 5, S_FC = 6;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, en = 1'b0, ip_load = 1'b0, user_irq = 1'b0;
  logic hm_start = 1'b0, hm_ack = 1'b0, irq_clear = 1'b0;
  logic [15:0] ip_incr = '0, ip_data = '0;
  logic [15:0] ip;
  logic exec_en, commit, hm_req, irq, fault;
  logic [1:0] fault_code;
  typedef struct {
    int sig;
    logic [15:0] val;
    string tag;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  always #5 sys_clk = ~sys_clk;
  mpu_ip_control #(.CODE_BYTES(4096), .HM_TIMEOUT(7)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .ip_incr(ip_incr),
    .ip_load(ip_load), .ip_data(ip_data), .user_irq(user_irq), .hm_start(hm_start),
    .hm_ack(hm_ack), .irq_clear(irq_clear), .ip(ip), .exec_en(exec_en), .commit(commit),
    .hm_req(hm_req), .irq(irq), .fault(fault), .fault_code(fault_code)
  );
  function automatic logic [15:0] obs_of(int s);
    return s == S_IP ? ip : s == S_EX ? {15'd0, exec_en} : s == S_CM ? {15'd0, commit} :
           s == S_HR ? {15'd0, hm_req} : s == S_IRQ ? {15'd0, irq} :
           s == S_F ? {15'd0, fault} : {14'd0, fault_code};
  endfunction
  task automatic chk(int s, logic [15:0] v, string tag);
    sb.push_back('{s, v, tag});
  endtask
  task automatic drain();
    exp_t e;
    logic [15:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs_of(e.sig);
      n_cmp++;
      assert (o === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk(S_IP, 0, "rst_ip"); chk(S_EX, 0, "rst_exec"); chk(S_CM, 0, "rst_commit");
    chk(S_HR, 0, "rst_hmreq"); chk(S_IRQ, 0, "rst_irq"); chk(S_F, 0, "rst_fault");
    chk(S_FC, 0, "rst_code");
    drain();
    sys_rst_n = 1'b1;
    tick();
    en = 1'b1; ip_incr = 16'd4;
    chk(S_EX, 0, "idle_exec"); chk(S_CM, 0, "idle_commit");
    drain();
    tick();
    for (int i = 0; i < 8; i++) begin
      chk(S_IP, 16'(4 * i), "run_ip"); chk(S_CM, 1, "run_commit"); chk(S_EX, 1, "run_exec");
      drain();
      tick();
    end
    ip_load = 1'b1; ip_data = 16'h0100;
    chk(S_IP, 16'h0020, "pre_load_ip");
    drain();
    tick();
    ip_data = 16'h0020;
    chk(S_IP, 16'h0100, "load_ip");
    drain();
    tick();
    ip_data = 16'h1000;
    chk(S_IP, 16'h0020, "reload_ip"); chk(S_CM, 1, "oob_commit");
    drain();
    tick();
    ip_load = 1'b0;
    chk(S_F, 1, "oob_fault"); chk(S_FC, 1, "oob_code"); chk(S_IP, 16'h0020, "oob_ip");
    chk(S_EX, 0, "halt_exec"); chk(S_CM, 0, "halt_commit");
    drain();
    tick();
    en = 1'b0;
    chk(S_IP, 16'h0020, "halt_frozen");
    drain();
    tick();
    en = 1'b1;
    chk(S_IP, 0, "idle_ip"); chk(S_F, 1, "held_fault"); chk(S_FC, 1, "held_code");
    drain();
    tick();
    chk(S_F, 0, "clr_fault"); chk(S_FC, 0, "clr_code"); chk(S_IP, 0, "rerun_ip");
    drain();
    tick();
    tick();
    hm_start = 1'b1; ip_incr = 16'd12;
    chk(S_IP, 16'd8, "hm_ip"); chk(S_CM, 0, "hm_start_commit"); chk(S_HR, 0, "hm_req_pre");
    drain();
    tick();
    hm_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk(S_HR, i == 1 ? 16'd1 : 16'd0, "hm_req_pulse"); chk(S_CM, 0, "hm_wait_commit");
      chk(S_IP, 16'd8, "hm_wait_ip"); chk(S_EX, 0, "hm_wait_exec");
      drain();
      tick();
    end
    hm_ack = 1'b1;
    chk(S_CM, 1, "hm_ack_commit");
    drain();
    tick();
    hm_ack = 1'b0; ip_incr = 16'd4; hm_start = 1'b1;
    chk(S_IP, 16'd20, "hm_done_ip"); chk(S_HR, 0, "hm_req_done"); chk(S_EX, 1, "hm_done_exec");
    drain();
    tick();
    hm_start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk(S_F, 0, "to_wait_fault"); chk(S_EX, 0, "to_wait_exec");
      drain();
      tick();
    end
    chk(S_F, 1, "to_fault"); chk(S_FC, 2, "to_code"); chk(S_IP, 16'd20, "to_ip");
    drain();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    hm_start = 1'b1;
    chk(S_IP, 0, "to2_ip"); chk(S_F, 0, "to2_fault");
    drain();
    tick();
    hm_start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    hm_ack = 1'b1;
    chk(S_CM, 1, "edge_ack_commit");
    drain();
    tick();
    hm_ack = 1'b0; ip_incr = 16'd2; user_irq = 1'b1;
    chk(S_F, 0, "edge_ack_fault"); chk(S_EX, 1, "edge_ack_run"); chk(S_IP, 16'd4, "edge_ack_ip");
    chk(S_CM, 1, "irq_commit");
    drain();
    tick();
    user_irq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk(S_IRQ, 1, "irq_level"); chk(S_IP, 16'd6, "irq_ip"); chk(S_EX, 0, "irq_exec");
      drain();
      tick();
    end
    irq_clear = 1'b1;
    drain();
    tick();
    irq_clear = 1'b0; hm_ack = 1'b1;
    chk(S_IRQ, 0, "irq_cleared"); chk(S_EX, 1, "irq_run"); chk(S_IP, 16'd6, "irq_run_ip");
    chk(S_CM, 1, "stray_ack_commit");
    drain();
    tick();
    hm_ack = 1'b0; hm_start = 1'b1;
    chk(S_IP, 16'd8, "stray_ack_ip");
    drain();
    tick();
    hm_start = 1'b0; en = 1'b0;
    chk(S_HR, 1, "abort_hmreq");
    drain();
    tick();
    hm_ack = 1'b1;
    chk(S_IP, 0, "abort_ip"); chk(S_EX, 0, "abort_exec"); chk(S_CM, 0, "late_ack_commit");
    drain();
    tick();
    hm_ack = 1'b0; en = 1'b1;
    tick();
    ip_incr = 16'd0;
    chk(S_IP, 0, "late_ack_ip"); chk(S_EX, 1, "late_ack_run");
    drain();
    tick();
    chk(S_F, 1, "zero_fault"); chk(S_FC, 3, "zero_code");
    drain();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    ip_incr = 16'd4;
    chk(S_F, 0, "zero_clr_fault"); chk(S_FC, 0, "zero_clr_code");
    drain();
    tick();
    hm_start = 1'b1;
    drain();
    tick();
    hm_start = 1'b0;
    chk(S_HR, 1, "pre_rst_hmreq"); chk(S_IP, 16'd4, "pre_rst_ip");
    drain();
    sys_rst_n = 1'b0;
    chk(S_HR, 0, "async_rst_hmreq"); chk(S_IP, 0, "async_rst_ip"); chk(S_EX, 0, "async_rst_exec");
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
